// File: rtl/adder_axi_sequencer.sv
// adder_axi_sequencer: AXI4-Lite master that writes two operands to the adder slave, then reads back the sum and the overflow flag
module adder_axi_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_A = 0,
  parameter int ADDR_B = 4,
  parameter int ADDR_RES = 8,
  parameter int ADDR_OVF = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    error,
  output logic [2:0]              err_state,
  output logic                    err_timeout,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);
  typedef enum logic [2:0] {IDLE = 3'd0, WR_A = 3'd1, WR_B = 3'd2, RD_RES = 3'd3, RD_OVF = 3'd4, FIN = 3'd5} state_t;
  localparam logic [31:0] LAST = 32'(TIMEOUT - 1);
  state_t state;
  logic [DATA_WIDTH-1:0] b_q;
  logic [31:0] cnt;
  logic aw_d, w_d, b_d, aw_ok, w_ok, b_ok, wr_st, rd_st, r_hs, bad, fin, tmo;
  assign m1_axi_wstrb = {(DATA_WIDTH/8){m1_axi_wvalid}};
  always_comb begin
    wr_st = state == WR_A || state == WR_B;
    rd_st = state == RD_RES || state == RD_OVF;
    aw_ok = aw_d | (m1_axi_awvalid & m1_axi_awready);
    w_ok = w_d | (m1_axi_wvalid & m1_axi_wready);
    b_ok = b_d | (m1_axi_bvalid & m1_axi_bready);
    r_hs = rd_st & m1_axi_rvalid & m1_axi_rready;
    bad = wr_st ? m1_axi_bvalid & m1_axi_bready & ~m1_axi_bresp : r_hs & ~m1_axi_rresp;
    fin = wr_st ? aw_ok & w_ok & b_ok : r_hs;
    tmo = TIMEOUT != 0 && (wr_st || rd_st) && cnt == LAST && !fin && !bad;
  end
  always_ff @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      state <= IDLE;
      b_q <= '0;
      cnt <= '0;
      {aw_d, w_d, b_d} <= '0;
      {busy, done, overflow, error, err_timeout} <= '0;
      result <= '0;
      err_state <= '0;
      m1_axi_awaddr <= '0;
      m1_axi_wdata <= '0;
      m1_axi_araddr <= '0;
      {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_rready} <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      aw_d <= aw_ok;
      w_d <= w_ok;
      b_d <= b_ok;
      m1_axi_awvalid <= m1_axi_awvalid & ~m1_axi_awready;
      m1_axi_wvalid <= m1_axi_wvalid & ~m1_axi_wready;
      m1_axi_bready <= m1_axi_bready & ~m1_axi_bvalid;
      if (r_hs && state == RD_RES) result <= m1_axi_rdata;
      if (r_hs && state == RD_OVF) overflow <= m1_axi_rdata[0];
      case (state)
        IDLE: if (start) begin
          state <= WR_A;
          b_q <= op_b;
          busy <= 1'b1;
          {error, err_timeout} <= '0;
          err_state <= '0;
          cnt <= '0;
          {aw_d, w_d, b_d} <= '0;
          m1_axi_awaddr <= ADDR_WIDTH'(ADDR_A);
          m1_axi_wdata <= op_a;
          {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready} <= '1;
        end
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: if (bad || tmo) begin
          state <= FIN;
          {busy, done, error, err_timeout} <= {1'b0, 1'b1, 1'b1, tmo};
          err_state <= state;
          {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_rready} <= '0;
        end else if (fin) begin
          cnt <= '0;
          {aw_d, w_d, b_d} <= '0;
          case (state)
            WR_A: begin
              state <= WR_B;
              m1_axi_awaddr <= ADDR_WIDTH'(ADDR_B);
              m1_axi_wdata <= b_q;
              {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready} <= '1;
            end
            WR_B: begin
              state <= RD_RES;
              {m1_axi_awvalid, m1_axi_wvalid, m1_axi_bready} <= '0;
              m1_axi_araddr <= ADDR_WIDTH'(ADDR_RES);
              {m1_axi_arvalid, m1_axi_rready} <= '1;
            end
            RD_RES: begin
              state <= RD_OVF;
              m1_axi_araddr <= ADDR_WIDTH'(ADDR_OVF);
            end
            default: begin
              state <= FIN;
              {busy, done} <= 2'b01;
              {m1_axi_arvalid, m1_axi_rready} <= '0;
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_axi_sequencer.sv
// tb_adder_axi_sequencer: directed bench with a configurable AXI4-Lite adder slave around adder_axi_sequencer
module tb_adder_axi_sequencer;
  logic clk, aresetn, start, busy, done, overflow, error, err_timeout;
  logic [31:0] op_a, op_b, result, wdata, rdata;
  logic [2:0] err_state;
  logic [7:0] awaddr, araddr;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bresp, bvalid, bready, arvalid, arready, rresp, rvalid, rready;
  int n_cmp, n_bad, lat;
  int aw_lat, w_lat, bad_wr;
  bit b_early, ar_tie, no_r_ovf;
  bit aw_got, w_got, ar_taken;
  int aw_seen, w_seen, ar_seen, b_cnt;
  logic [7:0] wa, rd_a;
  logic [31:0] wd, ra, rb;
  logic [32:0] sum;
  int n_done, n_writes, n_reads, n_dup, n_awfirst, n_ar_ovf, n_ar_drop, n_arv, n_strb;
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  logic [31:0] rd_log [4];

  adder_axi_sequencer #(.TIMEOUT(16)) dut (
    .m1_axi_aclk(clk), .m1_axi_aresetn(aresetn), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .error(error),
    .err_state(err_state), .err_timeout(err_timeout),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_ch();
    {aw_got, w_got, ar_taken} = '0;
    {aw_seen, w_seen, ar_seen, b_cnt} = '0;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 1;
    rresp = 1;
    rdata = '0;
  endtask

  task automatic clr();
    clr_ch();
    {n_done, n_writes, n_reads, n_dup, n_awfirst, n_ar_ovf, n_ar_drop, n_arv, n_strb} = '0;
    for (int i = 0; i < 4; i++) begin
      wr_addr[i] = 'x;
      wr_data[i] = 'x;
      rd_log[i] = 'x;
    end
  endtask

  task automatic cfg(input int al, input int wl, input bit be, input bit at, input int bw, input bit nr);
    aw_lat = al;
    w_lat = wl;
    b_early = be;
    ar_tie = at;
    bad_wr = bw;
    no_r_ovf = nr;
    clr();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!aresetn) clr_ch();
      else begin
        if (done) n_done++;
        if (!awvalid && wvalid) n_awfirst++;
        if (arvalid) n_arv++;
        if (arvalid && araddr == 8'h0C) n_ar_ovf++;
        if (busy && ar_taken && !arvalid) n_ar_drop++;
        if (wvalid && wstrb != 4'hF) n_strb++;
        if (awvalid && !aw_got) begin
          awready = aw_seen >= aw_lat;
          aw_seen++;
          if (awready) begin aw_got = 1; wa = awaddr; end
        end else begin
          if (awvalid) n_dup++;
          awready = 0;
          aw_seen = 0;
        end
        if (wvalid && !w_got) begin
          wready = w_seen >= w_lat;
          w_seen++;
          if (wready) begin w_got = 1; wd = wdata; end
        end else begin
          if (wvalid) n_dup++;
          wready = 0;
          w_seen = 0;
        end
        bvalid = 0;
        if (aw_got && w_got) begin
          if ((b_early || b_cnt >= 1) && bready) begin
            bvalid = 1;
            bresp = n_writes != bad_wr;
            if (n_writes < 4) begin wr_addr[n_writes] = 32'(wa); wr_data[n_writes] = wd; end
            if (wa == 8'h00) ra = wd;
            if (wa == 8'h04) rb = wd;
            n_writes++;
            {aw_got, w_got} = '0;
            b_cnt = 0;
          end else b_cnt++;
        end
        rvalid = 0;
        if (ar_taken) begin
          arready = ar_tie;
          if (!(no_r_ovf && rd_a == 8'h0C)) begin
            sum = {1'b0, ra} + {1'b0, rb};
            rvalid = 1;
            rresp = 1;
            rdata = rd_a == 8'h08 ? sum[31:0] : {31'd0, sum[32]};
            if (n_reads < 4) rd_log[n_reads] = 32'(rd_a);
            n_reads++;
            ar_taken = 0;
          end
        end else if (arvalid) begin
          arready = ar_tie || ar_seen >= 1;
          ar_seen++;
          if (arready) begin ar_taken = 1; ar_seen = 0; rd_a = araddr; end
        end else begin
          arready = ar_tie;
          ar_seen = 0;
        end
      end
    end
  end

  task automatic wait_done();
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b);
    op_a = a;
    op_b = b;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", error, 0);
    wait_done();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    aresetn = 0;
    start = 0;
    op_a = 0;
    op_b = 0;
    ra = 0;
    rb = 0;
    cfg(1, 1, 0, 0, -1, 0);
    settle(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_err_state", err_state, 0);
    chk("rst_wstrb", wstrb, 0);
    aresetn = 1;
    settle(2);

    cfg(1, 1, 0, 0, -1, 0);
    go(32'h5, 32'h7);
    chk("t1_result", result, 32'hC);
    chk("t1_overflow", overflow, 0);
    chk("t1_error", error, 0);
    chk("t1_busy_in_fin", busy, 0);
    settle(3);
    chk("t1_done_once", n_done, 1);
    chk("t1_writes", n_writes, 2);
    chk("t1_wr0_addr", wr_addr[0], 32'h0);
    chk("t1_wr0_data", wr_data[0], 32'h5);
    chk("t1_wr1_addr", wr_addr[1], 32'h4);
    chk("t1_wr1_data", wr_data[1], 32'h7);
    chk("t1_reads", n_reads, 2);
    chk("t1_rd0_addr", rd_log[0], 32'h8);
    chk("t1_rd1_addr", rd_log[1], 32'hC);
    chk("t1_strb", n_strb, 0);

    cfg(0, 0, 1, 1, -1, 0);
    go(32'h12345678, 32'h11111111);
    chk("t2_latency", lat, 6);
    chk("t2_result", result, 32'h23456789);
    chk("t2_error", error, 0);
    settle(3);
    chk("t2_writes", n_writes, 2);
    chk("t2_dup", n_dup, 0);
    chk("t2_ar_drop", n_ar_drop, 0);
    chk("t2_reads", n_reads, 2);
    chk("t2_done_once", n_done, 1);

    cfg(1, 4, 0, 0, -1, 0);
    go(32'hFFFFFFFF, 32'h1);
    chk("t3_result", result, 32'h0);
    chk("t3_overflow", overflow, 1);
    chk("t3_error", error, 0);
    settle(3);
    chk("t3_aw_first", n_awfirst, 6);
    chk("t3_wr0_data", wr_data[0], 32'hFFFFFFFF);
    chk("t3_writes", n_writes, 2);
    chk("t3_dup", n_dup, 0);

    cfg(1, 1, 0, 0, 1, 0);
    go(32'd10, 32'd20);
    chk("t4_error", error, 1);
    chk("t4_err_state", err_state, 2);
    chk("t4_err_timeout", err_timeout, 0);
    chk("t4_overflow_held", overflow, 1);
    settle(3);
    chk("t4_no_ar", n_arv, 0);
    chk("t4_reads", n_reads, 0);
    chk("t4_done_once", n_done, 1);

    cfg(1, 1, 0, 0, -1, 1);
    go(32'd3, 32'd4);
    chk("t5_error", error, 1);
    chk("t5_err_state", err_state, 4);
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_result", result, 32'd7);
    settle(3);
    chk("t5_ar_cycles", n_ar_ovf, 16);
    chk("t5_ar_rready_low", {arvalid, rready}, 0);
    chk("t5_done_once", n_done, 1);

    cfg(1, 1, 0, 0, -1, 0);
    op_a = 32'h40;
    op_b = 32'h2;
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!(awvalid && awaddr == 8'h04) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_reached_wr_b", {awvalid, awaddr}, {1'b1, 8'h04});
    aresetn = 0;
    @(negedge clk);
    chk("t6_rst_busy_done", {busy, done}, 0);
    chk("t6_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("t6_rst_addr", awaddr, 0);
    chk("t6_rst_wdata", wdata, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_err", {error, err_timeout, err_state}, 0);
    settle(2);
    aresetn = 1;
    settle(2);
    chk("t6_no_done", n_done, 0);
    cfg(1, 1, 0, 0, -1, 0);
    op_a = 32'h100;
    op_b = 32'h23;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    op_a = 32'hAAAA;
    op_b = 32'hBBBB;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    chk("t6_result", result, 32'h123);
    chk("t6_error", error, 0);
    settle(20);
    chk("t6_done_once", n_done, 1);
    chk("t6_writes", n_writes, 2);
    chk("t6_wr0_data", wr_data[0], 32'h100);
    chk("t6_wr1_data", wr_data[1], 32'h23);
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
